ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical clk_sys samples needed to accept a PS/2 clock level change (range 2..15).
REQ-002 Parameter TIMEOUT, default 50000: clk_sys cycles allowed between filtered falling edges inside a frame (17-bit counter).
REQ-003 clk_sys  input  1  system clock; the single clock domain, all flops on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 ps2_kbd_clk  input  1  raw PS/2 clock, asynchronous to clk_sys.
REQ-006 ps2_kbd_data  input  1  raw PS/2 data, asynchronous to clk_sys.
REQ-007 code  output  8  scancode at FIFO head; valid only while code_valid=1.
REQ-008 code_valid  output  1  high while FIFO is non-empty.
REQ-009 code_rd  input  1  one-cycle pop strobe from the downstream keyboard decoder.
REQ-010 frame_err  output  1  one-cycle pulse on a rejected frame (start, parity, stop or timeout).
REQ-011 overflow  output  1  sticky flag set when a good frame is dropped because storage is full.

Function
REQ-012 Both raw inputs SHALL pass through a 2-flop synchronizer; synchronizer flops reset to 1.
REQ-013 The filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples that differ from it; resets to 1.
REQ-014 A falling edge SHALL be a registered 1->0 transition of the filtered clock; data is sampled from the synchronized data line in the same cycle.
REQ-015 FSM states: IDLE, RECV, CHECK.
REQ-016 IDLE: on a falling edge with data=0 (start bit) go to RECV with bitcnt=1; on a falling edge with data=1 stay in IDLE, no error.
REQ-017 RECV: each falling edge shifts data in LSB-first and increments bitcnt; the edge that sets bitcnt to 11 moves to CHECK.
REQ-018 CHECK (exactly one cycle): accept iff the 8 data bits plus parity bit have odd parity and the stop bit is 1; accept -> push byte; reject -> pulse frame_err; always return to IDLE.
REQ-019 Latency: code_valid SHALL rise exactly 2 clk_sys cycles after the cycle the stop-bit falling edge is detected, given an empty FIFO.
REQ-020 Timeout: in RECV, a cycle counter clears on each falling edge; reaching TIMEOUT SHALL pulse frame_err, discard the partial frame, and return to IDLE.
REQ-021 FIFO: depth 4, 8 bits wide, 2-bit wrapping read/write pointers plus 3-bit count (0..4).
REQ-022 code_rd with code_valid=1 pops one entry; code_rd with code_valid=0 is ignored.
REQ-023 Push and pop in the same cycle SHALL both succeed at any count, including full (count unchanged, no overflow).
REQ-024 Push while full without pop SHALL drop the new byte, keep stored bytes, and set overflow.
REQ-025 overflow clears on the next accepted pop; a simultaneous drop and pop leaves it set.
REQ-026 code SHALL reflect the head entry combinationally from storage and SHALL not change while code_valid=1 and no pop occurs.

Reset
REQ-027 Reset SHALL force: FSM=IDLE, bitcnt=0, timeout counter=0, pointers and count=0, code_valid=0, frame_err=0, overflow=0, code=0, filtered clock=1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only at the next start bit.

Configuration
REQ-029 Macro PS2_RX_FIFO_EN defined: 4-entry FIFO as in REQ-021..REQ-026.
REQ-030 PS2_RX_FIFO_EN undefined: one holding register; a push while it is full without a pop is dropped and sets overflow; all other requirements are unchanged.

Verification
REQ-031 Frame 0x1C (parity 0, stop 1) at a 12.5 kHz PS/2 clock -> code=0x1C and code_valid=1, 2 cycles after the stop edge; frame_err stays 0.
REQ-032 Frame 0xF0 sent with parity 0 (wrong) -> exactly one frame_err pulse; code_valid stays 0.
REQ-033 Start bit then 4 bits, then the line idles for TIMEOUT+10 cycles -> one frame_err pulse; a following 0x29 frame is received correctly.
REQ-034 Five good frames 0x01..0x05 with no code_rd -> FIFO holds 0x01..0x04 and overflow=1; four pops return 0x01..0x04 and the first pop clears overflow.
REQ-035 A 3-cycle low glitch on ps2_kbd_clk with FILTER_LEN=4 -> no bit is shifted and the FSM stays in IDLE.
REQ-036 With the FIFO full, a push and code_rd in the same cycle -> count stays 4, overflow stays 0, and the new byte lands at the tail.

Source files
------------

// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: sync + glitch filter + frame FSM + scancode store.
// Latency: code_valid rises 2 clk_sys cycles after the stop-bit falling edge is detected.
// Backpressure: none upstream (PS/2 cannot be held off); full store drops new bytes and sets overflow.
//
// Ports:
//   clk_sys, reset_n            - system clock, async active-low reset
//   ps2_kbd_clk, ps2_kbd_data   - raw PS/2 lines (asynchronous)
//   code, code_valid, code_rd   - head scancode, non-empty flag, pop strobe
//   frame_err                   - one-cycle pulse on a rejected or timed-out frame
//   overflow                    - sticky; set on a dropped good byte, cleared by the next pop
// Build option: define PS2_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module ps2_rx #(
    parameter int FILTER_LEN = 4,      // 2..15
    parameter int TIMEOUT    = 50000   // fits a 17-bit counter
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_rd,
    output logic       frame_err,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Synchronizers, clock filter, falling-edge detect
    // ---------------------------------------------------------------
    logic       r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic       r_filt_clk, r_filt_prev;
    logic [3:0] r_filt_cnt;
    logic       w_fall;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_s1    <= ps2_kbd_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= ps2_kbd_data;
            r_dat_s2    <= r_dat_s1;
            r_filt_prev <= r_filt_clk;
            // r_filt_cnt counts consecutive samples disagreeing with the
            // filtered level; the FILTER_LEN-th such sample flips it.
            if (r_clk_s2 != r_filt_clk) begin
                if (r_filt_cnt == 4'(FILTER_LEN - 1)) begin
                    r_filt_clk <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 4'd1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt_clk;

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic [9:0]  r_shift, w_shift_nxt;     // {stop, parity, d7..d0} once complete
    logic [16:0] r_to_cnt, w_to_cnt_nxt;
    logic        w_ok, w_push, w_err;
    logic        r_frame_err;

    // Odd parity over data+parity, and stop bit must be high.
    assign w_ok = (^r_shift[8:0]) & r_shift[9];

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_to_cnt_nxt = '0;
        w_push       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_nxt  = ST_RECV;
                    w_bitcnt_nxt = 4'd1;
                end
            end
            ST_RECV: begin
                if (w_fall) begin
                    w_shift_nxt  = {r_dat_s2, r_shift[9:1]};
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd10) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (r_to_cnt == 17'(TIMEOUT - 1)) begin
                    w_err        = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    w_bitcnt_nxt = '0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 17'd1;
                end
            end
            ST_CHECK: begin
                w_push       = w_ok;
                w_err        = ~w_ok;
                w_state_nxt  = ST_IDLE;
                w_bitcnt_nxt = '0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_bitcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_frame_err <= w_err;
        end
    end

    assign frame_err = r_frame_err;

    // ---------------------------------------------------------------
    // Scancode storage
    // ---------------------------------------------------------------
    logic w_pop, w_full, w_drop;
    logic r_overflow;

    assign w_pop  = code_rd & code_valid;
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign w_drop = w_push & w_full & ~w_pop;

`ifdef PS2_RX_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;
    logic       w_wr;

    assign w_full = (r_count == 3'd4);
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift[7:0];
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign code       = r_mem[r_rd_ptr];
    assign code_valid = (r_count != 3'd0);
`else
    logic [7:0] r_hold;
    logic       r_full;
    logic       w_wr;

    assign w_full = r_full;
    assign w_wr   = w_push & (~r_full | w_pop);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_wr) begin
                r_hold <= r_shift[7:0];
                r_full <= 1'b1;
            end else if (w_pop) begin
                r_full <= 1'b0;
            end
        end
    end

    assign code       = r_hold;
    assign code_valid = r_full;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_pop) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
// Testbench for ps2_rx: PS/2 frames driven at a 12.5 kHz bit clock against a 1 MHz clk_sys.
// Expected bytes, errors and overflow come from a queue model of the scancode store.
// Storage depth follows PS2_RX_FIFO_EN (4 entries) or its absence (1 entry).
module tb_ps2_rx;

    localparam int FL = 4;
    localparam int TO = 200;
    localparam int H  = 40;   // PS/2 half period in clk_sys cycles (40 us)
`ifdef PS2_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_kbd_clk = 1'b1;
    logic       ps2_kbd_data = 1'b1;
    logic       code_rd = 1'b0;
    logic [7:0] code;
    logic       code_valid, frame_err, overflow;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_kbd_clk (ps2_kbd_clk),
        .ps2_kbd_data(ps2_kbd_data),
        .code        (code),
        .code_valid  (code_valid),
        .code_rd     (code_rd),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #500 clk_sys = ~clk_sys;

    int nvec = 0;
    int nmis = 0;
    int err_cnt = 0;

    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    // reference model of the scancode store
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0;

    typedef struct {
        logic [7:0] d;
        bit         par_bad;
        bit         stop;
        bit         exp_ok;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // mode 0: plain bit; 1: check code_valid latency; 2: pulse code_rd in the push cycle
    task automatic ps2_bit(input bit b, input int mode);
        ps2_kbd_data = b;
        tick(H);
        ps2_kbd_clk = 1'b0;
        if (mode == 1) begin
            // 2 sync flops + FILTER_LEN samples put the detected edge 6 edges out;
            // code_valid follows 2 cycles later.
            repeat (7) @(posedge clk_sys);
            #1 chk("latency_pre", code_valid, 1'b0);
            @(posedge clk_sys);
            #1 chk("latency_post", code_valid, 1'b1);
            tick(H - 8);
        end else if (mode == 2) begin
            repeat (7) @(posedge clk_sys);
            @(negedge clk_sys);
            code_rd = 1'b1;
            @(negedge clk_sys);
            code_rd = 1'b0;
            tick(H - 8);
        end else begin
            tick(H);
        end
        ps2_kbd_clk = 1'b1;
    endtask

    function automatic bit par_bit(input logic [7:0] d, input bit par_bad);
        return (~^d) ^ par_bad;
    endfunction

    function automatic bit frame_ok(input logic [7:0] d, input bit p, input bit stop);
        return ((($countones(d) + int'(p)) % 2) == 1) && stop;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop,
                              input int nbits, input int mode);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = par_bit(d, par_bad);
        f[10]   = stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i], (i == 10) ? mode : 0);
        end
        ps2_kbd_data = 1'b1;
        tick(3 * H);
    endtask

    task automatic model_accept(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf = 1'b1;
    endtask

    task automatic pop_chk(input string nm);
        chk({nm, "_vld"}, code_valid, 1'b1);
        if (exp_q.size() > 0) begin
            chk({nm, "_code"}, code, exp_q[0]);
            void'(exp_q.pop_front());
        end
        code_rd = 1'b1;
        tick(1);
        code_rd = 1'b0;
        exp_ovf = 1'b0;
        tick(1);
        chk({nm, "_ovf"}, overflow, exp_ovf);
    endtask

    task automatic state_chk(input string nm);
        chk({nm, "_vld"}, code_valid, (exp_q.size() > 0));
        if (exp_q.size() > 0) chk({nm, "_code"}, code, exp_q[0]);
        chk({nm, "_ovf"}, overflow, exp_ovf);
    endtask

    initial begin
        int e0;
        logic [7:0] d;
        bit pb, pbad, stp, ok;
        int r;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{8'hF0, 1'b1, 1'b1, 1'b0};   // parity sent as 0: wrong
        tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'hA5, 1'b0, 1'b0, 1'b0};   // bad stop bit
        tbl[5] = '{8'h29, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b0, 1'b1, 1'b1};

        // reset state
        tick(5);
        chk("rst_code_valid", code_valid, 1'b0);
        chk("rst_code", code, 8'h00);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset_n = 1'b1;
        tick(10);

        // 0x1C with latency check
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1);
        chk("f1c_err", err_cnt - e0, 0);
        exp_q.push_back(8'h1C);
        pop_chk("f1c");

        // table vectors
        for (int i = 0; i < 7; i++) begin
            e0 = err_cnt;
            send_frame(tbl[i].d, tbl[i].par_bad, tbl[i].stop, 11, 0);
            chk($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].exp_ok ? 0 : 1);
            chk($sformatf("tbl%0d_vld", i), code_valid, tbl[i].exp_ok);
            if (tbl[i].exp_ok) begin
                exp_q.push_back(tbl[i].d);
                pop_chk($sformatf("tbl%0d", i));
            end
        end

        // timeout: start + 4 bits then idle
        e0 = err_cnt;
        send_frame(8'h0F, 1'b0, 1'b1, 5, 0);
        tick(TO + 10);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_vld", code_valid, 1'b0);
        e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b1, 11, 0);
        chk("after_to_err", err_cnt - e0, 0);
        exp_q.push_back(8'h29);
        pop_chk("after_to");

        // 3-cycle clock glitch with data low must not start a frame
        e0 = err_cnt;
        ps2_kbd_data = 1'b0;
        tick(H);
        ps2_kbd_clk = 1'b0;
        tick(3);
        ps2_kbd_clk = 1'b1;
        tick(H);
        ps2_kbd_data = 1'b1;
        tick(3 * H);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 0);
        chk("glitch_err", err_cnt - e0, 0);
        exp_q.push_back(8'h5A);
        pop_chk("glitch");

        // reset mid-frame
        e0 = err_cnt;
        send_frame(8'hC3, 1'b0, 1'b1, 5, 0);
        reset_n = 1'b0;
        tick(5);
        reset_n = 1'b1;
        tick(10);
        send_frame(8'h33, 1'b0, 1'b1, 11, 0);
        chk("midrst_err", err_cnt - e0, 0);
        exp_q.push_back(8'h33);
        pop_chk("midrst");

        // five frames without pops
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 11, 0);
            model_accept(8'(i));
        end
        state_chk("ovf_full");
        for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("ovf_pop%0d", i));
        chk("ovf_empty", code_valid, 1'b0);

        // full store: push and pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 11, 0);
            model_accept(8'h10 + 8'(i));
        end
        send_frame(8'h77, 1'b0, 1'b1, 11, 2);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        state_chk("simul");
        for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("simul_pop%0d", i));
        chk("simul_empty", code_valid, 1'b0);

        // randomized frames against the model
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            r    = $urandom_range(0, 7);
            pbad = (r <= 1);
            stp  = (r != 2);
            pb   = par_bit(d, pbad);
            ok   = frame_ok(d, pb, stp);
            e0   = err_cnt;
            send_frame(d, pbad, stp, 11, 0);
            chk($sformatf("rnd%0d_err", n), err_cnt - e0, ok ? 0 : 1);
            if (ok) model_accept(d);
            state_chk($sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) pop_chk($sformatf("rnd%0d_pop", n));
        end
        while (exp_q.size() > 0) pop_chk("drain");
        chk("drain_empty", code_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
